// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, FSM states and digit key codes.
package keypad_scanner_pkg;

  localparam int unsigned KEY_ROWS   = 4;
  localparam int unsigned KEY_COLS   = 4;
  localparam int unsigned DEF_CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // Digit keys on a phone-style layout: {row_idx, col_idx}
  localparam logic [3:0] KEY_1 = 4'h0;
  localparam logic [3:0] KEY_2 = 4'h1;
  localparam logic [3:0] KEY_3 = 4'h2;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h8;
  localparam logic [3:0] KEY_8 = 4'h9;
  localparam logic [3:0] KEY_9 = 4'hA;
  localparam logic [3:0] KEY_0 = 4'hD;

  // Index of the lowest-numbered active-low row; 0 when none is low
  function automatic logic [1:0] lowest_low_row(input logic [KEY_ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/SCAN_HZ clocks.
module scan_tick_gen
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
  parameter int unsigned SCAN_HZ = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);

  localparam int unsigned DIV   = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = (cnt_q == TERM);

  always_comb begin
    cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: column rotation, tick-based debounce, one pulse per new press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_ROWS-1:0] row_n,
  output logic [KEY_COLS-1:0] col_n,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                tick_c;
  logic [KEY_ROWS-1:0] row_meta_q, rs_n_q;

  scan_state_e         state_q, state_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [KEY_COLS-1:0] col_n_q, col_n_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                key_valid_q, key_valid_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_held_q, key_held_d;

  logic [1:0]          col_step_c;
  logic [1:0]          low_row_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                rows_idle_c;

  scan_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst),
    .tick_c (tick_c)
  );

  // Two-stage synchronizer; idle rows read as released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= '1;
      rs_n_q     <= '1;
    end else begin
      row_meta_q <= row_n;
      rs_n_q     <= row_meta_q;
    end
  end

  assign col_step_c  = col_idx_q + 2'd1;
  assign low_row_c   = lowest_low_row(rs_n_q);
  assign cnt_inc_c   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);
  assign rows_idle_c = (rs_n_q == '1);

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;

    if (tick_c) begin
      unique case (state_q)
        ST_SCAN: begin
          if (rows_idle_c) begin
            col_idx_d = col_step_c;
          end else begin
            row_idx_d = low_row_c;
            cnt_d     = CNT_ONE;
            if (CNT_DONE == CNT_ONE) begin
              key_valid_d = 1'b1;
              key_code_d  = {low_row_c, col_idx_q};
              key_held_d  = 1'b1;
              state_d     = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!rs_n_q[row_idx_q]) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_DONE) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_idx_q, col_idx_q};
              key_held_d  = 1'b1;
              state_d     = ST_HELD;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_step_c;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rows_idle_c) begin
            if (CNT_DONE == CNT_ONE) begin
              cnt_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_step_c;
              state_d    = ST_SCAN;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (rows_idle_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_DONE) begin
              cnt_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_step_c;
              state_d    = ST_SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives rows, a monitor checks each key_valid.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Key (r,c) is bit r*4+c; a closed key pulls its row low while its column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] v, input bit want_eq);
    for (int i = 0; i < 100; i++) begin
      if ((col_n == v) == want_eq) return;
      wait_clks(1);
    end
    check("col_wait_timeout", {28'd0, col_n}, {28'd0, v});
  endtask

  task automatic wait_col_entry(input logic [3:0] v);
    wait_col(v, 1'b0);
    wait_col(v, 1'b1);
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every key_valid must match the oldest expected code
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: got code %0h expected no pulse at %0t", key_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("key_code_at_valid", {28'd0, key_code}, {28'd0, e});
        check("key_held_at_valid", {31'd0, key_held}, 32'd1);
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    wait_clks(3);
    check("reset_col_n", {28'd0, col_n}, 32'hE);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_code", {28'd0, key_code}, 32'd0);
    check("reset_key_held", {31'd0, key_held}, 32'd0);

    // Idle scan: column steps every 10 clocks
    @(negedge clk) rst = 1'b1;
    wait_clks(9);
    check("idle_col_pre_tick", {28'd0, col_n}, 32'hE);
    wait_clks(1);
    check("idle_col_1", {28'd0, col_n}, 32'hD);
    wait_clks(10);
    check("idle_col_2", {28'd0, col_n}, 32'hB);
    wait_clks(10);
    check("idle_col_3", {28'd0, col_n}, 32'h7);
    wait_clks(10);
    check("idle_col_wrap", {28'd0, col_n}, 32'hE);

    // Row 2 / col 1 press and release
    exp_q.push_back(4'b1001);
    keys[9] = 1'b1;
    wait_clks(100);
    check("r2c1_held", {31'd0, key_held}, 32'd1);
    check("r2c1_code", {28'd0, key_code}, 32'h9);
    keys[9] = 1'b0;
    wait_clks(25);
    check("r2c1_held_during_release", {31'd0, key_held}, 32'd1);
    wait_clks(35);
    check("r2c1_released", {31'd0, key_held}, 32'd0);
    drained("r2c1_pending");

    // Bounce on row 1 / col 0: two low samples, then high, then stable
    wait_col_entry(4'hE);
    keys[4] = 1'b1;
    wait_clks(24);
    keys[4] = 1'b0;
    wait_clks(10);
    exp_q.push_back(4'b0100);
    keys[4] = 1'b1;
    wait_clks(100);
    check("bounce_held", {31'd0, key_held}, 32'd1);
    keys[4] = 1'b0;
    wait_clks(60);
    check("bounce_released", {31'd0, key_held}, 32'd0);
    drained("bounce_pending");

    // Rows 0 and 3 on col 2: lowest row wins; col 0 key while held is ignored
    exp_q.push_back(4'b0010);
    keys[2]  = 1'b1;
    keys[14] = 1'b1;
    wait_clks(100);
    check("multi_code", {28'd0, key_code}, 32'h2);
    keys[0] = 1'b1;
    wait_clks(60);
    check("second_key_still_held", {31'd0, key_held}, 32'd1);
    check("second_key_code_kept", {28'd0, key_code}, 32'h2);
    keys = '0;
    wait_clks(60);
    check("multi_released", {31'd0, key_held}, 32'd0);
    drained("multi_pending");

    // Release glitch: short release must fall back to HELD without a new pulse
    exp_q.push_back(4'b0111);
    keys[7] = 1'b1;
    wait_clks(100);
    check("glitch_code", {28'd0, key_code}, 32'h7);
    keys[7] = 1'b0;
    wait_clks(25);
    keys[7] = 1'b1;
    wait_clks(30);
    check("glitch_still_held", {31'd0, key_held}, 32'd1);
    keys[7] = 1'b0;
    wait_clks(60);
    check("glitch_released", {31'd0, key_held}, 32'd0);
    drained("glitch_pending");

    // Reset after three debounce samples on row 2 / col 0
    wait_col_entry(4'hE);
    keys[8] = 1'b1;
    wait_clks(34);
    rst = 1'b0;
    #1;
    check("midrst_col_n", {28'd0, col_n}, 32'hE);
    check("midrst_key_held", {31'd0, key_held}, 32'd0);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_key_code", {28'd0, key_code}, 32'd0);
    keys = '0;
    wait_clks(3);
    @(negedge clk) rst = 1'b1;
    wait_clks(60);
    drained("midrst_pending");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
